// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - forwarding selects, hazard FSM states and shadow-stage type
package fwd_pkg;

    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_DI   = 2'b01;
    localparam logic [1:0] FWD_ALUM = 2'b10;

    // Shadow register index is stored at a fixed width; narrower indices are zero-extended.
    localparam int RW_MAX = 8;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } haz_state_e;

    typedef struct packed {
        logic              valid;
        logic [RW_MAX-1:0] rw;
        logic              RegWr;
        logic              MemRd;
    } shadow_t;

    // r0 is hardwired, so a write to it never produces a value worth forwarding.
    function automatic logic producer_hits(input shadow_t s, input logic [RW_MAX-1:0] src);
        return s.valid && s.RegWr && (s.rw != '0) && (s.rw == src);
    endfunction

endpackage

// File: rtl/ex_fwd_hazard_ctrl_if.sv
// rtl/ex_fwd_hazard_ctrl_if.sv - ID-side request and EX/fetch control bundle of the hazard controller
interface ex_fwd_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] rs_ID;
    logic [REG_AW-1:0] rt_ID;
    logic              useRs_ID;
    logic              useRt_ID;
    logic [REG_AW-1:0] rw_ID;
    logic              RegWr_ID;
    logic              MemRd_ID;
    logic              flush_ID;
    logic              stall_ext;
    logic [1:0]        BusAFw;
    logic [1:0]        BusBFw;
    logic              pc_wr_en;
    logic              ifid_wr_en;
    logic              idex_bubble;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output rs_ID, rt_ID, useRs_ID, useRt_ID, rw_ID, RegWr_ID, MemRd_ID,
        output flush_ID, stall_ext,
        input  BusAFw, BusBFw, pc_wr_en, ifid_wr_en, idex_bubble, stall_cnt
    );

    modport slave (
        input  rs_ID, rt_ID, useRs_ID, useRt_ID, rw_ID, RegWr_ID, MemRd_ID,
        input  flush_ID, stall_ext,
        output BusAFw, BusBFw, pc_wr_en, ifid_wr_en, idex_bubble, stall_cnt
    );
endinterface

// File: rtl/fwd_src_sel.sv
// rtl/fwd_src_sel.sv - per-source forwarding select and load-use detect against EX/M producers
module fwd_src_sel
    import fwd_pkg::*;
(
    input  logic [RW_MAX-1:0] src,
    input  logic              use_src,
    input  shadow_t           ex_stage,
    input  shadow_t           m_stage,
    output logic [1:0]        sel,
    output logic              load_use
);

    logic ex_hit;
    logic m_hit;
    logic unused_m_memrd;

    assign ex_hit = use_src && producer_hits(ex_stage, src);
    assign m_hit  = use_src && producer_hits(m_stage, src);

    // A load in M already has its data in W by the time the consumer is in EX.
    assign unused_m_memrd = m_stage.MemRd;

    always_comb begin
        sel = FWD_REG;
        if (ex_hit) begin
            sel = FWD_ALUM;
        end else if (m_hit) begin
            sel = FWD_DI;
        end
    end

    assign load_use = ex_hit && ex_stage.MemRd;

endmodule

// File: rtl/ex_fwd_hazard_ctrl.sv
// rtl/ex_fwd_hazard_ctrl.sv - EX operand forwarding and load-use/flush/freeze sequencing
// Optional feature macro: HAZ_FORWARD_EN (undefined: no forwarding, stall on any EX/M dependency)
module ex_fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    ex_fwd_hazard_ctrl_if.slave bus
);

    shadow_t           ex_q;
    shadow_t           m_q;
    shadow_t           w_q;
    shadow_t           id_entry;
    haz_state_e        state_q;
    haz_state_e        state_d;
    logic [REG_AW-1:0] rs_id;
    logic [REG_AW-1:0] rt_id;
    logic [REG_AW-1:0] rw_id;
    logic [RW_MAX-1:0] src_a;
    logic [RW_MAX-1:0] src_b;
    logic [1:0]        sel_a;
    logic [1:0]        sel_b;
    logic              lu_a;
    logic              lu_b;
    logic [1:0]        fw_a_q;
    logic [1:0]        fw_b_q;
    logic [1:0]        fw_a_d;
    logic [1:0]        fw_b_d;
    logic              hazard_stall;
    logic              bubble;
    logic [CNT_W-1:0]  cnt_q;
    logic              unused_sink;

    assign rs_id = bus.rs_ID;
    assign rt_id = bus.rt_ID;
    assign rw_id = bus.rw_ID;
    assign src_a = RW_MAX'(rs_id);
    assign src_b = RW_MAX'(rt_id);

    assign id_entry = '{valid: 1'b1, rw: RW_MAX'(rw_id), RegWr: bus.RegWr_ID, MemRd: bus.MemRd_ID};

    fwd_src_sel u_sel_a (
        .src      (src_a),
        .use_src  (bus.useRs_ID),
        .ex_stage (ex_q),
        .m_stage  (m_q),
        .sel      (sel_a),
        .load_use (lu_a)
    );

    fwd_src_sel u_sel_b (
        .src      (src_b),
        .use_src  (bus.useRt_ID),
        .ex_stage (ex_q),
        .m_stage  (m_q),
        .sel      (sel_b),
        .load_use (lu_b)
    );

`ifdef HAZ_FORWARD_EN
    // The cycle after a load-use stall sees the load in M, so the check is masked there.
    assign hazard_stall = (state_q == RUN) && (lu_a || lu_b) && !bus.flush_ID;
    assign fw_a_d       = bubble ? FWD_REG : sel_a;
    assign fw_b_d       = bubble ? FWD_REG : sel_b;
    assign unused_sink  = ^w_q;
`else
    // Without bypass paths every live EX/M dependency waits for register-file write-through.
    assign hazard_stall = ((sel_a != FWD_REG) || (sel_b != FWD_REG)) && !bus.flush_ID;
    assign fw_a_d       = FWD_REG;
    assign fw_b_d       = FWD_REG;
    assign unused_sink  = ^{w_q, lu_a, lu_b};
`endif

    always_comb begin
        bus.pc_wr_en   = 1'b1;
        bus.ifid_wr_en = 1'b1;
        bubble         = 1'b0;
        if (rst_n) begin
            if (bus.stall_ext) begin
                bus.pc_wr_en   = 1'b0;
                bus.ifid_wr_en = 1'b0;
            end else if (bus.flush_ID) begin
                bubble = 1'b1;
            end else if (hazard_stall) begin
                bus.pc_wr_en   = 1'b0;
                bus.ifid_wr_en = 1'b0;
                bubble         = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef HAZ_FORWARD_EN
        case (state_q)
            RUN:      if (hazard_stall) state_d = LU_STALL;
            LU_STALL: state_d = RUN;
            default:  state_d = RUN;
        endcase
`else
        state_d = RUN;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q    <= '0;
            m_q     <= '0;
            w_q     <= '0;
            state_q <= RUN;
            fw_a_q  <= FWD_REG;
            fw_b_q  <= FWD_REG;
            cnt_q   <= '0;
        end else if (!bus.stall_ext) begin
            ex_q    <= bubble ? shadow_t'('0) : id_entry;
            m_q     <= ex_q;
            w_q     <= m_q;
            state_q <= state_d;
            fw_a_q  <= fw_a_d;
            fw_b_q  <= fw_b_d;
            if (hazard_stall && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.idex_bubble = bubble;
    assign bus.BusAFw      = fw_a_q;
    assign bus.BusBFw      = fw_b_q;
    assign bus.stall_cnt   = cnt_q;

endmodule

// File: doc/ex_fwd_hazard_ctrl.md
# ex_fwd_hazard_ctrl

Forwarding and hazard controller for the 5-stage pipeline. It tracks the destination register of the instructions in the EX, M and W stages in an internal shadow pipeline. It compares those destinations with the source registers of the instruction in ID, then registers the bus-A/bus-B forwarding selects into EX for the EX-stage 3:1 operand muxes. It also sequences load-use stalls, ID flushes and external freezes by driving PC/IF-ID write enables and an ID/EX bubble.

## Interface
Parameters:
- `REG_AW`, 5: register-index width.
- `CNT_W`, 16: stall-counter width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `rs_ID`, `rt_ID`  in  REG_AW: source indices of the ID instruction.
- `useRs_ID`, `useRt_ID`  in  1: ID instruction actually reads rs/rt.
- `rw_ID`  in  REG_AW: destination index of the ID instruction.
- `RegWr_ID`  in  1: ID instruction writes the register file.
- `MemRd_ID`  in  1: ID instruction is a load.
- `flush_ID`  in  1: kill the ID instruction (taken branch/jump).
- `stall_ext`  in  1: global freeze (memory wait).
- `BusAFw`, `BusBFw`  out  2: EX operand selects. 00 = busX_EX, 01 = Di (W data), 10 = ALUout_M. 11 is never driven.
- `pc_wr_en`, `ifid_wr_en`  out  1: PC and IF/ID register write enables.
- `idex_bubble`  out  1: load a NOP into ID/EX this edge.
- `stall_cnt`  out  CNT_W: saturating count of hazard-stall cycles.

## Operation
- The shadow pipeline holds `{valid, rw, RegWr, MemRd}` for EX, M and W. It advances on every edge unless `stall_ext`=1.
  - On a bubble, EX receives `valid`=0.
  - A producer counts only if `valid`, `RegWr`=1 and `rw`≠0.
- Match rules, evaluated per source (A = rs, B = rt) only when the matching `useX_ID`=1:
  - Producer in EX matches: next select is 10, because the producer will be in M when the consumer reaches EX.
  - Producer in M matches: next select is 01, because the producer will be in W.
  - Both match: EX wins (youngest), so the select is 10.
  - Otherwise: 00.
  - A producer in W is not forwarded. The register file's write-through covers that case.
- Load-use: the EX producer matches and has `MemRd`=1, and `flush_ID`=0.
  - Raise `pc_wr_en`=0, `ifid_wr_en`=0, `idex_bubble`=1 for exactly one cycle.
  - Next cycle the load is in M and the select resolves to 01.
- FSM states are RUN and LU_STALL.
  - RUN → LU_STALL on a load-use hazard.
  - LU_STALL → RUN unconditionally on the next non-frozen edge.
  - A LU_STALL is never chained, because the re-check sees the load in M.
- Priority, highest first:
  - `rst_n`=0.
  - `stall_ext`: hold all state; `pc_wr_en`=`ifid_wr_en`=0; `idex_bubble`=0; counter holds.
  - `flush_ID`: `idex_bubble`=1; enables stay 1; no stall is raised even if a hazard matches.
  - Hazard stall.
  - Normal advance.
- `stall_cnt` increments once per hazard-stall cycle (not `stall_ext` cycles). It saturates at all-ones.

## Timing
- `BusAFw`/`BusBFw` are registered: computed in ID and valid for the whole following EX cycle.
  - They update only on edges where ID/EX loads.
  - On a bubble edge they load 00.
  - They hold while `stall_ext`=1.
- `pc_wr_en`, `ifid_wr_en` and `idex_bubble` are combinational from the current ID inputs, the shadow EX/M state and `stall_ext`. Latency is the same cycle.
- Reset values:
  - `BusAFw`=`BusBFw`=00.
  - All shadow `valid`=0.
  - FSM in RUN.
  - `pc_wr_en`=`ifid_wr_en`=1, `idex_bubble`=0.
  - `stall_cnt`=0.
- Reset asserted mid-LU_STALL returns to RUN on that edge. No bubble is pending afterward.

## Configuration
- `HAZ_FORWARD_EN` defined: forwarding behaviour as above.
- `HAZ_FORWARD_EN` undefined:
  - Selects are tied to 00.
  - Any match against a valid EX or M producer (load or not) stalls: enables 0, bubble 1.
  - The condition is re-evaluated every cycle, giving up to 2 stall cycles.
  - The FSM is unused (held in RUN).
  - `stall_cnt` still counts.

## Structure
- Package `fwd_pkg` holds:
  - Select constants `FWD_REG`=2'b00, `FWD_DI`=2'b01, `FWD_ALUM`=2'b10.
  - The FSM state enum.
  - The shadow-stage struct `{valid, rw, RegWr, MemRd}`.
- Sub-module `fwd_src_sel` is instantiated twice (rs and rt). It is combinational: it takes one source index and the EX/M shadow stages, and returns the select plus a load-use flag.

## Test plan
- `add r3` in EX, ID reads rs=r3 → next-cycle `BusAFw`=10, `BusBFw`=00, no stall.
- `add r3` in M, ID reads rt=r3 → `BusBFw`=01. The same r3 in both EX and M → 10.
- `lw r5` in EX, ID uses rs=r5 → one cycle of `pc_wr_en`=0 and `idex_bubble`=1, then `BusAFw`=01; `stall_cnt`=1.
- Write to r0 in EX, ID reads r0 → select 00, no stall.
- Load-use with `flush_ID`=1 → bubble and no stall. `stall_ext`=1 held 3 cycles in LU_STALL → selects and counter frozen, resumes correctly.
- `HAZ_FORWARD_EN` undefined, `add r3` in EX, ID reads r3 → 2 stall cycles, selects 00, `stall_cnt`=2.
